// File: rtl/auto_focus_search_pkg.sv
// Shared definitions for the auto-focus contrast search.
//   af_state_t : search controller states
//   af_phase_t : scan pass (coarse sweep, then fine sweep around the coarse peak)
//   CYC_50MS / CYC_100MS : clk cycle counts at 59 MHz
//   TMR_W      : width of the shared settle / frame-timeout counter
package auto_focus_search_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        WAIT_MOT,
        SETTLE,
        SKIP,
        MEASURE,
        PARK,
        FAIL
    } af_state_t;

    typedef enum logic {
        COARSE,
        FINE
    } af_phase_t;

    localparam int unsigned CLK_HZ    = 59_000_000;
    localparam int unsigned CYC_50MS  = 2_950_000;
    localparam int unsigned CYC_100MS = 5_900_000;
    localparam int unsigned TMR_W     = 32;

endpackage

// File: rtl/auto_focus_search_timer.sv
// af_cycle_timer: loadable down-counter with terminal-count flag.
//   clk, rst (sync, active-low)
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : start value; tc asserts load_val cycles after the load
//   tc       : count has reached zero (holds there)
module af_cycle_timer
    import auto_focus_search_pkg::*;
#(
    parameter int unsigned W = TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/auto_focus_search.sv
// auto_focus_search: two-pass contrast search for the focus motor.
// A coarse sweep (step COARSE_STEP over 0..POS_MAX) is followed by a unit-step
// sweep of +/-COARSE_STEP around the coarse peak; the lens is then parked at
// the best position found.
//   clk, rst           : clock, synchronous active-low reset
//   auto_focus_trig    : start request (rising edge)
//   auto_focus_active  : 0 aborts a running search
//   frame_done         : end-of-frame pulse, sharp_metric valid with it
//   pos_cmd/pos_valid/pos_ready : absolute position command handshake
//   motor_done         : motor reached the commanded position
//   focus_pos          : last position accepted by the motor
//   af_busy            : search in progress
//   af_done / af_fail  : single-cycle completion / failure pulses
module auto_focus_search
    import auto_focus_search_pkg::*;
#(
    parameter int unsigned POS_W       = 8,
    parameter int unsigned POS_MAX     = 240,
    parameter int unsigned COARSE_STEP = 16,
    parameter int unsigned METRIC_W    = 24,
    parameter int unsigned SETTLE_CYC  = CYC_50MS,
    parameter int unsigned FRAME_TMO   = CYC_100MS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                auto_focus_trig,
    input  logic                auto_focus_active,
    input  logic                frame_done,
    input  logic [METRIC_W-1:0] sharp_metric,
    output logic [POS_W-1:0]    pos_cmd,
    output logic                pos_valid,
    input  logic                pos_ready,
    input  logic                motor_done,
    output logic [POS_W-1:0]    focus_pos,
    output logic                af_busy,
    output logic                af_done,
    output logic                af_fail
);

    // Scan arithmetic runs one bit wider so target+step cannot wrap.
    localparam logic [POS_W:0] MAX_X  = (POS_W+1)'(POS_MAX);
    localparam logic [POS_W:0] STEP_X = (POS_W+1)'(COARSE_STEP);

    af_state_t            state,       state_nxt;
    af_phase_t            phase,       phase_nxt;
    logic                 parking,     parking_nxt;
    logic [POS_W-1:0]     target,      target_nxt;
    logic [POS_W-1:0]     step,        step_nxt;
    logic [POS_W-1:0]     scan_hi,     scan_hi_nxt;
    logic [METRIC_W-1:0]  best_metric, best_metric_nxt;
    logic [POS_W-1:0]     best_pos,    best_pos_nxt;
    logic [POS_W-1:0]     focus_q,     focus_nxt;
    logic                 trig_q;
    logic                 armed;
    logic                 trig_edge;

    logic [METRIC_W-1:0]  meas_best;
    logic [POS_W-1:0]     meas_pos;
    logic [POS_W:0]       sum_x;
    logic [POS_W:0]       fine_lo_x;
    logic [POS_W:0]       fine_hi_x;

    logic                 tmr_load;
    logic [TMR_W-1:0]     tmr_val;
    logic                 tmr_tc;

    logic                 pos_valid_c;
    logic                 af_done_c;
    logic                 af_fail_c;

    af_cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // trig_q alone clears to 0 in reset, so a trig held high through reset
    // would look like an edge; armed requires trig to be seen low first.
    assign trig_edge = armed && auto_focus_trig && !trig_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            phase       <= COARSE;
            parking     <= 1'b0;
            target      <= '0;
            step        <= '0;
            scan_hi     <= '0;
            best_metric <= '0;
            best_pos    <= '0;
            focus_q     <= '0;
            trig_q      <= 1'b0;
            armed       <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            parking     <= parking_nxt;
            target      <= target_nxt;
            step        <= step_nxt;
            scan_hi     <= scan_hi_nxt;
            best_metric <= best_metric_nxt;
            best_pos    <= best_pos_nxt;
            focus_q     <= focus_nxt;
            trig_q      <= auto_focus_trig;
            armed       <= armed || !auto_focus_trig;
        end
    end

    always_comb begin
        state_nxt       = state;
        phase_nxt       = phase;
        parking_nxt     = parking;
        target_nxt      = target;
        step_nxt        = step;
        scan_hi_nxt     = scan_hi;
        best_metric_nxt = best_metric;
        best_pos_nxt    = best_pos;
        focus_nxt       = focus_q;
        tmr_load        = 1'b0;
        tmr_val         = '0;
        pos_valid_c     = 1'b0;
        af_done_c       = 1'b0;
        af_fail_c       = 1'b0;
        meas_best       = best_metric;
        meas_pos        = best_pos;
        sum_x           = {1'b0, target} + {1'b0, step};
        fine_lo_x       = '0;
        fine_hi_x       = '0;

        case (state)
            IDLE: begin
                if (trig_edge && auto_focus_active) begin
                    state_nxt       = MOVE;
                    phase_nxt       = COARSE;
                    parking_nxt     = 1'b0;
                    target_nxt      = '0;
                    step_nxt        = POS_W'(COARSE_STEP);
                    scan_hi_nxt     = POS_W'(POS_MAX);
                    best_metric_nxt = '0;
                    best_pos_nxt    = '0;
                end
            end

            MOVE: begin
                // Gated by active so an abort drops the request immediately.
                pos_valid_c = auto_focus_active;
                if (auto_focus_active && pos_ready) begin
                    focus_nxt = target;
                    state_nxt = WAIT_MOT;
                end
            end

            WAIT_MOT: begin
                if (motor_done) begin
                    if (parking) begin
                        state_nxt = PARK;
                    end else begin
                        state_nxt = SETTLE;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(SETTLE_CYC - 1);
                    end
                end
            end

            SETTLE: begin
                if (tmr_tc) begin
                    state_nxt = SKIP;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(FRAME_TMO - 1);
                end
            end

            SKIP: begin
                if (frame_done) begin
                    state_nxt = MEASURE;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(FRAME_TMO - 1);
                end else if (tmr_tc) begin
                    state_nxt = FAIL;
                end
            end

            MEASURE: begin
                if (frame_done) begin
                    if (sharp_metric > best_metric) begin
                        meas_best = sharp_metric;
                        meas_pos  = target;
                    end
                    best_metric_nxt = meas_best;
                    best_pos_nxt    = meas_pos;
                    fine_lo_x = ({1'b0, meas_pos} >= STEP_X) ?
                                ({1'b0, meas_pos} - STEP_X) : '0;
                    fine_hi_x = {1'b0, meas_pos} + STEP_X;
                    if (fine_hi_x > MAX_X) begin
                        fine_hi_x = MAX_X;
                    end

                    if (sum_x <= {1'b0, scan_hi}) begin
                        target_nxt = sum_x[POS_W-1:0];
                        state_nxt  = MOVE;
                    end else if (phase == COARSE) begin
                        if (meas_best == '0) begin
                            state_nxt = FAIL;
                        end else begin
                            phase_nxt   = FINE;
                            step_nxt    = POS_W'(1);
                            target_nxt  = fine_lo_x[POS_W-1:0];
                            scan_hi_nxt = fine_hi_x[POS_W-1:0];
                            state_nxt   = MOVE;
                        end
                    end else begin
                        // Park reuses MOVE/WAIT_MOT; WAIT_MOT routes to PARK.
                        parking_nxt = 1'b1;
                        target_nxt  = meas_pos;
                        state_nxt   = MOVE;
                    end
                end else if (tmr_tc) begin
                    state_nxt = FAIL;
                end
            end

            PARK: begin
                af_done_c = 1'b1;
                state_nxt = IDLE;
            end

            FAIL: begin
                af_fail_c = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state != IDLE && state != FAIL && !auto_focus_active) begin
            state_nxt = FAIL;
        end
    end

    assign pos_cmd   = target;
    assign pos_valid = pos_valid_c;
    assign focus_pos = focus_q;
    assign af_busy   = (state != IDLE);
    assign af_done   = af_done_c;
    assign af_fail   = af_fail_c;

endmodule

// File: tb/tb_auto_focus_search.sv
module tb_auto_focus_search;

    localparam int PMAX = 64;
    localparam int STEP = 16;
    localparam int TMO  = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        auto_focus_trig;
    logic        auto_focus_active;
    logic        frame_done;
    logic [23:0] sharp_metric;
    logic [7:0]  pos_cmd;
    logic        pos_valid;
    logic        pos_ready;
    logic        motor_done;
    logic [7:0]  focus_pos;
    logic        af_busy;
    logic        af_done;
    logic        af_fail;

    auto_focus_search #(
        .POS_W       (8),
        .POS_MAX     (PMAX),
        .COARSE_STEP (STEP),
        .METRIC_W    (24),
        .SETTLE_CYC  (4),
        .FRAME_TMO   (TMO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .auto_focus_trig   (auto_focus_trig),
        .auto_focus_active (auto_focus_active),
        .frame_done        (frame_done),
        .sharp_metric      (sharp_metric),
        .pos_cmd           (pos_cmd),
        .pos_valid         (pos_valid),
        .pos_ready         (pos_ready),
        .motor_done        (motor_done),
        .focus_pos         (focus_pos),
        .af_busy           (af_busy),
        .af_done           (af_done),
        .af_fail           (af_fail)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  metric_tab [0:255];
    int  cmds [$];
    int  exp_q [$];
    bit  exp_ok;
    bit  mot_en = 1'b0;
    bit  frm_en = 1'b0;
    bit  frm_once = 1'b0;
    int  done_cnt = 0;

    // Motor: random ready, records accepted commands, pulses done 1..4 cycles later.
    initial begin
        pos_ready  = 1'b0;
        motor_done = 1'b0;
        forever begin
            @(negedge clk);
            motor_done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) motor_done = 1'b1;
            end
            pos_ready = mot_en && ($urandom_range(0, 2) != 0);
            if (pos_valid && pos_ready && auto_focus_active) begin
                cmds.push_back(int'(pos_cmd));
                done_cnt = $urandom_range(1, 4);
            end
        end
    end

    // Video: frames every 5..12 cycles, metric taken from the lens position.
    initial begin
        int fcnt = 0;
        int fper = 7;
        frame_done   = 1'b0;
        sharp_metric = '0;
        forever begin
            @(negedge clk);
            frame_done = 1'b0;
            if (frm_once) begin
                frm_once     = 1'b0;
                frame_done   = 1'b1;
                sharp_metric = 24'(metric_tab[focus_pos]);
            end else if (frm_en) begin
                fcnt++;
                if (fcnt >= fper) begin
                    fcnt         = 0;
                    fper         = $urandom_range(5, 12);
                    frame_done   = 1'b1;
                    sharp_metric = 24'(metric_tab[focus_pos]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic set_mode(input int m);
        for (int p = 0; p < 256; p++) begin
            case (m)
                0: metric_tab[p] = 1000 - ((p > 37) ? (p - 37) : (37 - p)) * 10;
                1: metric_tab[p] = (p == 16 || p == 32) ? 500 : 0;
                2: metric_tab[p] = 0;
                default: metric_tab[p] = int'($urandom_range(0, 4)) * 250;
            endcase
        end
    endtask

    // Expected position sequence from the search rules: coarse sweep, fine sweep, park.
    task automatic build_model();
        int best = 0;
        int bp   = 0;
        int lo, hi;
        exp_q.delete();
        for (int p = 0; p <= PMAX; p += STEP) begin
            exp_q.push_back(p);
            if (metric_tab[p] > best) begin best = metric_tab[p]; bp = p; end
        end
        if (best == 0) begin
            exp_ok = 1'b0;
            return;
        end
        lo = (bp >= STEP) ? bp - STEP : 0;
        hi = (bp + STEP <= PMAX) ? bp + STEP : PMAX;
        for (int p = lo; p <= hi; p++) begin
            exp_q.push_back(p);
            if (metric_tab[p] > best) begin best = metric_tab[p]; bp = p; end
        end
        exp_q.push_back(bp);
        exp_ok = 1'b1;
    endtask

    task automatic do_search(input string tag, input bit poke);
        int  n_done = 0;
        int  n_fail = 0;
        bit  fin    = 1'b0;
        int  n;
        build_model();
        cmds.delete();
        mot_en = 1'b1;
        frm_en = 1'b1;
        auto_focus_trig = 1'b0;
        tick();
        auto_focus_trig = 1'b1;
        tick();
        chk({tag, "_busy_after_edge"}, 64'(af_busy), 64'd1);
        auto_focus_trig = 1'b0;
        for (int k = 0; k < 6000 && !fin; k++) begin
            tick();
            if (poke && k == 40) auto_focus_trig = 1'b1;
            if (poke && k == 43) auto_focus_trig = 1'b0;
            if (af_done) n_done++;
            if (af_fail) n_fail++;
            if (af_done || af_fail) fin = 1'b1;
        end
        repeat (3) begin
            tick();
            if (af_done) n_done++;
            if (af_fail) n_fail++;
        end
        chk({tag, "_done_pulses"}, 64'(n_done), exp_ok ? 64'd1 : 64'd0);
        chk({tag, "_fail_pulses"}, 64'(n_fail), exp_ok ? 64'd0 : 64'd1);
        chk({tag, "_num_cmds"}, 64'(cmds.size()), 64'(exp_q.size()));
        n = (cmds.size() < exp_q.size()) ? cmds.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_cmd%0d", tag, i), 64'(cmds[i]), 64'(exp_q[i]));
        chk({tag, "_focus_pos"}, 64'(focus_pos), 64'(exp_q[exp_q.size()-1]));
        chk({tag, "_idle_busy"}, 64'(af_busy), 64'd0);
    endtask

    initial begin
        int  prev_pos;
        int  k;
        bit  seen;

        rst               = 1'b0;
        auto_focus_trig   = 1'b0;
        auto_focus_active = 1'b1;
        set_mode(0);
        repeat (3) tick();
        chk("reset_outputs", 64'({pos_valid, pos_cmd, focus_pos, af_busy, af_done, af_fail}), 64'd0);
        rst = 1'b1;
        tick();

        set_mode(0); do_search("clean", 1'b0);
        set_mode(1); do_search("tie", 1'b0);
        set_mode(2); do_search("zero", 1'b0);
        set_mode(3); do_search("rand_poke", 1'b1);

        // Abort while a command is held unaccepted.
        mot_en = 1'b0;
        frm_en = 1'b0;
        prev_pos = int'(focus_pos);
        auto_focus_trig = 1'b1;
        tick();
        auto_focus_trig = 1'b0;
        tick();
        tick();
        chk("abort_valid_held", 64'(pos_valid), 64'd1);
        chk("abort_cmd0", 64'(pos_cmd), 64'd0);
        auto_focus_active = 1'b0;
        tick();
        chk("abort_valid_dropped", 64'(pos_valid), 64'd0);
        chk("abort_fail_pulse", 64'(af_fail), 64'd1);
        chk("abort_focus_kept", 64'(focus_pos), 64'(prev_pos));
        auto_focus_active = 1'b1;
        tick();
        chk("abort_idle", 64'({af_busy, af_fail}), 64'd0);

        // Frame timeout in MEASURE.
        cmds.delete();
        mot_en = 1'b1;
        auto_focus_trig = 1'b1;
        tick();
        auto_focus_trig = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (motor_done) seen = 1'b1;
        end
        chk("tmo_motor_done_seen", 64'(seen), 64'd1);
        repeat (10) tick();
        frm_once = 1'b1;
        tick();
        k = 0;
        seen = 1'b0;
        for (int i = 1; i <= 200 && !seen; i++) begin
            tick();
            if (af_fail) begin seen = 1'b1; k = i; end
        end
        chk("tmo_fail_seen", 64'(seen), 64'd1);
        chk("tmo_cycles", 64'(k), 64'(TMO + 1));
        tick();
        chk("tmo_idle", 64'(af_busy), 64'd0);
        set_mode(3); do_search("restart", 1'b0);

        // Reset in the middle of SETTLE at the second coarse position.
        set_mode(0);
        cmds.delete();
        mot_en = 1'b1;
        frm_en = 1'b1;
        auto_focus_trig = 1'b1;
        tick();
        auto_focus_trig = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            if (motor_done && cmds.size() == 2) seen = 1'b1;
        end
        chk("rst_second_move", 64'(seen), 64'd1);
        chk("rst_pre_focus", 64'(focus_pos), 64'd16);
        tick();
        rst = 1'b0;
        auto_focus_trig = 1'b1;
        tick();
        chk("rst_mid_settle", 64'({pos_valid, pos_cmd, focus_pos, af_busy, af_done, af_fail}), 64'd0);
        tick();
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (af_busy || pos_valid) seen = 1'b1;
        end
        chk("trig_held_no_start", 64'(seen), 64'd0);
        chk("trig_held_no_cmd", 64'(cmds.size()), 64'd2);
        do_search("after_reset", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
